// File: rtl/gearbox_pkg.sv
// rtl/gearbox_pkg.sv - shared types and helpers for the fc gearbox pair
//
// Purpose: phase encoding and word-width helper shared by gearbox_1_to_2_fc
//          and gearbox_2_to_1_fc.
// Ports:   none (package).

package gearbox_pkg;

  // Which half of a packed word the narrow side is currently on.
  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

  localparam int GB_FIFO_DEPTH = 2;

  // Width of the wide word for a given narrow beat width.
  function automatic int word_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/ff_fifo_2.sv
// rtl/ff_fifo_2.sv - two-entry valid/ready FIFO with registered ready
//
// Purpose: small elastic buffer; in_ready is derived only from the stored
//          count, so it never depends on out_ready in the same cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     write side handshake
//   in_data   [dw]        write data
//   out_valid/out_ready   read side handshake
//   out_data  [dw]        head entry

module ff_fifo_2
  import gearbox_pkg::*;
#(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [dw-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [dw-1:0] out_data
);

  logic [dw-1:0] mem [0:1];
  logic          head;
  logic          tail;
  logic [1:0]    cnt;
  logic          push;
  logic          pop;

  assign in_ready  = (cnt != 2'(GB_FIFO_DEPTH));
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[head];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= 1'b0;
      tail <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      // 1-bit pointers wrap 1 -> 0 by inversion.
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_data;
  end

endmodule

// File: rtl/gearbox_1_to_2_fc.sv
// rtl/gearbox_1_to_2_fc.sv - packs pairs of narrow beats into wide words
//
// Purpose: consumes width-bit beats and emits {first, second} as one
//          2*width-bit word, at full up-side throughput.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   up_valid/up_ready/up_data   narrow input stream
//   down_valid/down_ready       wide output handshake
//   down_data [2*width]         packed word {first beat, second beat}
//   half_pending                upper half held, partner awaited

module gearbox_1_to_2_fc
  import gearbox_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [width-1:0]     up_data,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [2*width-1:0]   down_data,
  output logic                 half_pending
);

  localparam int ww = word_width(width);

  phase_e           phase;
  phase_e           phase_nxt;
  logic [width-1:0] half_reg;
  logic             up_hs;
  logic             fifo_in_valid;
  logic             fifo_in_ready;
  logic [ww-1:0]    fifo_in_data;

  // An upper half always fits; a lower half needs a free FIFO slot. A pop in
  // the same cycle is not credited, keeping down_ready off the up_ready path.
  assign up_ready      = (phase == PH_HI) | fifo_in_ready;
  assign up_hs         = up_valid & up_ready;
  assign half_pending  = (phase == PH_LO);

  assign fifo_in_valid = up_valid & (phase == PH_LO);
  assign fifo_in_data  = {half_reg, up_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_HI;
    else        phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    if (up_hs) begin
      case (phase)
        PH_HI:   phase_nxt = PH_LO;
        PH_LO:   phase_nxt = PH_HI;
        default: phase_nxt = PH_HI;
      endcase
    end
  end

  // The held half is only meaningful while phase is PH_LO, so no reset.
  always_ff @(posedge clk) begin
    if (up_hs && phase == PH_HI) half_reg <= up_data;
  end

  ff_fifo_2 #(
    .dw(ww)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (fifo_in_data),
    .out_valid (down_valid),
    .out_ready (down_ready),
    .out_data  (down_data)
  );

endmodule
